// File: rtl/match_index_scanner_pkg.sv
// Shared TCAM constants and the scanner FSM state type.
package tcam_pkg;

    localparam int TCAM_ENTRIES = 16;
    localparam int TCAM_IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        NOMATCH
    } state_t;

endpackage

// File: rtl/match_index_scanner_lsb_encoder.sv
// Combinational lowest-set-bit search over a hit vector.
module lowest_set_bit_encoder #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic [ENTRIES-1:0] vector,
    output logic [IDX_W-1:0]   index,
    output logic               any,
    output logic               one_hot_only
);

    always_comb begin
        index = '0;
        // Scan from the top down so the lowest set bit is the last to win.
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (vector[ENTRIES-1-i]) begin
                index = IDX_W'(ENTRIES - 1 - i);
            end
        end
        any          = |vector;
        one_hot_only = any && ((vector & (vector - ENTRIES'(1))) == '0);
    end

endmodule

// File: rtl/match_index_scanner.sv
// Turns a TCAM hit vector into a stream of matched indices.
// Define MULTI_HIT_EN to emit every set index; otherwise only the lowest one.
module match_index_scanner
    import tcam_pkg::*;
#(
    parameter int ENTRIES = TCAM_ENTRIES,
    parameter int IDX_W   = TCAM_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ENTRIES-1:0] hits,
    input  logic               hits_valid,
    output logic               in_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               no_match
);

    state_t             state;
    logic [ENTRIES-1:0] enc_vec;
    logic [IDX_W-1:0]   enc_index;
    logic               enc_any;
    logic               enc_one_hot;

`ifdef MULTI_HIT_EN
    logic [ENTRIES-1:0] pending;
    logic [ENTRIES-1:0] pending_rest;

    // One encoder serves both acceptance and the next-index lookahead.
    assign pending_rest = pending & (pending - ENTRIES'(1));
    assign enc_vec      = (state == IDLE) ? hits : pending_rest;
`else
    logic unused_one_hot;

    assign enc_vec        = hits;
    assign unused_one_hot = enc_one_hot;
`endif

    lowest_set_bit_encoder #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_encoder (
        .vector       (enc_vec),
        .index        (enc_index),
        .any          (enc_any),
        .one_hot_only (enc_one_hot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            no_match  <= 1'b0;
`ifdef MULTI_HIT_EN
            pending   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hits_valid) begin
                        in_ready <= 1'b0;
                        if (enc_any) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_index <= enc_index;
`ifdef MULTI_HIT_EN
                            out_last  <= enc_one_hot;
                            pending   <= hits;
`else
                            out_last  <= 1'b1;
`endif
                        end else begin
                            state    <= NOMATCH;
                            no_match <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
`ifdef MULTI_HIT_EN
                        if (out_last) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_index <= '0;
                            pending   <= '0;
                        end else begin
                            pending   <= pending_rest;
                            out_index <= enc_index;
                            out_last  <= enc_one_hot;
                        end
`else
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_index <= '0;
`endif
                    end
                end
                NOMATCH: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    no_match <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_index <= '0;
                    no_match  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_index_scanner.sv
// Self-checking bench for match_index_scanner; follows MULTI_HIT_EN like the design.
module tb_match_index_scanner;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [ENTRIES-1:0] hits;
    logic               hits_valid;
    logic               in_ready;
    logic [IDX_W-1:0]   out_index;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               no_match;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    match_index_scanner #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hits       (hits),
        .hits_valid (hits_valid),
        .in_ready   (in_ready),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .no_match   (no_match)
    );

    typedef struct {
        logic [ENTRIES-1:0] hits;
        int unsigned        first;
        int unsigned        n_multi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one vector and follows it to completion against a queue of expected indices.
    task automatic send(input logic [ENTRIES-1:0] h, input int unsigned stall_pct,
                        output int unsigned first, output int unsigned count);
        int unsigned q[$];
        int unsigned n;
        logic        do_hs;
        first = 0;
        count = 0;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        for (int i = 0; i < ENTRIES; i++) begin
            if (h[i]) begin
                q.push_back(i);
`ifndef MULTI_HIT_EN
                break;
`endif
            end
        end
        hits       = h;
        hits_valid = 1'b1;
        out_ready  = ($urandom_range(99) >= stall_pct);
        step();
        hits = ENTRIES'($urandom);
        if (h == '0) begin
            check("no_match_pulse", 32'(no_match), 32'd1);
            check("nomatch_out_valid", 32'(out_valid), 32'd0);
            check("nomatch_in_ready", 32'(in_ready), 32'd0);
            step();
            hits_valid = 1'b0;
            check("no_match_cleared", 32'(no_match), 32'd0);
            check("nomatch_in_ready_back", 32'(in_ready), 32'd1);
            check("nomatch_out_valid_after", 32'(out_valid), 32'd0);
            out_ready = 1'b0;
            return;
        end
        n = 0;
        while (q.size() > 0 && n < 400) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_index", 32'(out_index), q[0]);
            check("out_last", 32'(out_last), 32'(q.size() == 1));
            check("in_ready_busy", 32'(in_ready), 32'd0);
            check("no_match_busy", 32'(no_match), 32'd0);
            if (n == 0) first = 32'(out_index);
            do_hs = out_ready;
            step();
            n++;
            if (do_hs) begin
                void'(q.pop_front());
                count++;
            end
            if (q.size() == 0) hits_valid = 1'b0;
            out_ready = ($urandom_range(99) >= stall_pct);
            hits      = ENTRIES'($urandom);
        end
        hits_valid = 1'b0;
        if (q.size() != 0) check("emit_timeout", q.size(), 32'd0);
        check("out_valid_after_last", 32'(out_valid), 32'd0);
        check("in_ready_after_last", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        table_v[$];
        int unsigned first;
        int unsigned count;
        logic [ENTRIES-1:0] r;

        table_v.push_back('{16'h0010, 4, 1});
        table_v.push_back('{16'h8421, 0, 4});
        table_v.push_back('{16'h00C0, 6, 2});
        table_v.push_back('{16'h8000, 15, 1});
        table_v.push_back('{16'hFFFF, 0, 16});
        table_v.push_back('{16'h0001, 0, 1});
        table_v.push_back('{16'hA000, 13, 2});

        reset      = 1'b1;
        hits       = '0;
        hits_valid = 1'b0;
        out_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_no_match", 32'(no_match), 32'd0);
        check("reset_out_index", 32'(out_index), 32'd0);

        foreach (table_v[k]) begin
            send(table_v[k].hits, (k % 2 == 0) ? 0 : 40, first, count);
            check("table_first", first, table_v[k].first);
`ifdef MULTI_HIT_EN
            check("table_count", count, table_v[k].n_multi);
`else
            check("table_count", count, 32'd1);
`endif
        end

        // No match
        send('0, 0, first, count);

        // Backpressure: index 1 held for three stalled cycles
        hits       = 16'h0006;
        hits_valid = 1'b1;
        out_ready  = 1'b0;
        step();
        hits_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_index", 32'(out_index), 32'd1);
`ifdef MULTI_HIT_EN
            check("bp_hold_last", 32'(out_last), 32'd0);
`else
            check("bp_hold_last", 32'(out_last), 32'd1);
`endif
            step();
        end
        out_ready = 1'b1;
        check("bp_release_index", 32'(out_index), 32'd1);
        step();
`ifdef MULTI_HIT_EN
        check("bp_second_index", 32'(out_index), 32'd2);
        check("bp_second_last", 32'(out_last), 32'd1);
        check("bp_second_valid", 32'(out_valid), 32'd1);
        step();
`endif
        check("bp_done_valid", 32'(out_valid), 32'd0);
        check("bp_done_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Reset in the middle of an emission
        hits       = 16'hFFFF;
        hits_valid = 1'b1;
        step();
        hits_valid = 1'b0;
`ifdef MULTI_HIT_EN
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_index", 32'(out_index), 32'(i));
            step();
        end
`else
        check("rst_mid_index", 32'(out_index), 32'd0);
`endif
        reset      = 1'b1;
        hits_valid = 1'b1;
        hits       = 16'h0001;
        out_ready  = 1'b1;
        step();
        reset      = 1'b0;
        hits_valid = 1'b0;
        out_ready  = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_out_index", 32'(out_index), 32'd0);
        check("rst_mid_out_last", 32'(out_last), 32'd0);
        check("rst_mid_no_match", 32'(no_match), 32'd0);
        send(16'h0002, 0, first, count);
        check("post_rst_first", first, 32'd1);
        check("post_rst_count", count, 32'd1);

        // Randomized vectors of varying density and backpressure
        for (int t = 0; t < 40; t++) begin
            case (t % 4)
                0: r = ENTRIES'($urandom);
                1: r = ENTRIES'($urandom) & ENTRIES'($urandom) & ENTRIES'($urandom);
                2: r = ENTRIES'(1) << $urandom_range(ENTRIES - 1);
                default: r = ($urandom_range(3) == 0) ? '0 : ENTRIES'($urandom) | ENTRIES'($urandom);
            endcase
            send(r, $urandom_range(60), first, count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
